// File: rtl/seg7_mux_counter.sv
// seg7_mux_counter
// Multi-digit BCD seconds counter with a time-multiplexed seven-segment scan.
// A prescaler derives a one-cycle tick from clk. Each tick steps the BCD value
// up or down by one, with full wrap in both directions. A parallel load has
// priority over counting. A free-running refresh counter walks the scanned
// digit. The segment and digit-select outputs are registered, so they lag the
// scan index and bcd_out by one clock.
module seg7_mux_counter #(
    parameter int                    NUM_DIGITS   = 4,
    parameter int                    PRESCALE_W   = 24,
    parameter logic [PRESCALE_W-1:0] MAX_COUNT    = 24'd10_000_000,
    parameter logic [15:0]           REFRESH_DIV  = 16'd10_000,
    parameter bit                    COMMON_ANODE = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              div_in,
    input  logic                    enable,
    input  logic                    up_down,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    tick,
    output logic                    wrap,
    output logic [6:0]              segments,
    output logic [NUM_DIGITS-1:0]   digit_sel
);

    localparam int                    BCD_W        = 4 * NUM_DIGITS;
    localparam int                    IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX     = IDX_W'(NUM_DIGITS - 1);
    localparam logic [15:0]           REFRESH_LAST = REFRESH_DIV - 16'd1;
    localparam logic [6:0]            SEG_POL      = {7{COMMON_ANODE}};
    localparam logic [NUM_DIGITS-1:0] SEL_POL      = {NUM_DIGITS{COMMON_ANODE}};

    // Glyph table, segment order {g,f,e,d,c,b,a}, active-high. Non-BCD codes blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [PRESCALE_W-1:0] pre_reg;
    logic                  tick_reg;
    logic [BCD_W-1:0]      bcd_reg;
    logic                  wrap_reg;
    logic [15:0]           refresh_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [6:0]            segments_reg;
    logic [NUM_DIGITS-1:0] digit_sel_reg;

    // ------------------------------------------------------------------
    // Prescaler terminal value
    // ------------------------------------------------------------------
    logic [17:0]           div_scaled;
    logic [PRESCALE_W-1:0] cmp_value;

    assign div_scaled = {div_in, 10'b0};
    assign cmp_value  = (div_in == 8'd0) ? MAX_COUNT : PRESCALE_W'(div_scaled);

    // ------------------------------------------------------------------
    // BCD step logic: per-digit carry/borrow and load clamping
    // ------------------------------------------------------------------
    logic [3:0]            digit_cur [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] up_carry_in;
    logic [NUM_DIGITS-1:0] dn_borrow_in;
    logic                  up_wrap_next;
    logic                  dn_wrap_next;
    logic [BCD_W-1:0]      count_up_next;
    logic [BCD_W-1:0]      count_dn_next;
    logic [BCD_W-1:0]      load_clamped;

    // Ripple the carry/borrow from digit 0 upward. The carry out of the top
    // digit means the whole value has wrapped.
    always_comb begin
        logic carry;
        logic borrow;
        carry        = 1'b1;
        borrow       = 1'b1;
        up_carry_in  = '0;
        dn_borrow_in = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            up_carry_in[i]  = carry;
            dn_borrow_in[i] = borrow;
            carry           = carry  & (bcd_reg[4*i +: 4] == 4'd9);
            borrow          = borrow & (bcd_reg[4*i +: 4] == 4'd0);
        end
        up_wrap_next = carry;
        dn_wrap_next = borrow;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_cur[gi] = bcd_reg[4*gi +: 4];

            // Increment this digit only when every lower digit rolled over.
            assign count_up_next[4*gi +: 4] =
                !up_carry_in[gi]        ? digit_cur[gi] :
                (digit_cur[gi] == 4'd9) ? 4'd0 : digit_cur[gi] + 4'd1;

            // Decrement this digit only when every lower digit rolled under.
            assign count_dn_next[4*gi +: 4] =
                !dn_borrow_in[gi]       ? digit_cur[gi] :
                (digit_cur[gi] == 4'd0) ? 4'd9 : digit_cur[gi] - 4'd1;

            // Out-of-range load digits saturate at 9, so bcd_reg only ever holds valid BCD.
            assign load_clamped[4*gi +: 4] =
                (load_value[4*gi +: 4] > 4'd9) ? 4'd9 : load_value[4*gi +: 4];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Prescaler: counts while enabled and emits a one-cycle tick at the terminal value.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (load) begin
            pre_reg  <= '0;
            tick_reg <= 1'b0;
        end else if (enable) begin
            if (pre_reg == cmp_value) begin
                pre_reg  <= '0;
                tick_reg <= 1'b1;
            end else begin
                pre_reg  <= pre_reg + 1'b1;
                tick_reg <= 1'b0;
            end
        end else begin
            tick_reg <= 1'b0;
        end
    end

    // BCD counter: steps on the cycle after tick. wrap is high together with the wrapped value.
    always_ff @(posedge clk) begin
        if (reset) begin
            bcd_reg  <= '0;
            wrap_reg <= 1'b0;
        end else if (load) begin
            bcd_reg  <= load_clamped;
            wrap_reg <= 1'b0;
        end else if (tick_reg) begin
            bcd_reg  <= up_down ? count_up_next : count_dn_next;
            wrap_reg <= up_down ? up_wrap_next  : dn_wrap_next;
        end else begin
            wrap_reg <= 1'b0;
        end
    end

    // Refresh timer and scan index: free running and not gated by enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_reg <= 16'd0;
            idx_reg     <= '0;
        end else if (refresh_reg == REFRESH_LAST) begin
            refresh_reg <= 16'd0;
            idx_reg     <= (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
        end else begin
            refresh_reg <= refresh_reg + 16'd1;
        end
    end

    // Display registers: drive the glyph and select for the current scan index, with polarity applied.
    always_ff @(posedge clk) begin
        if (reset) begin
            segments_reg  <= 7'h3F ^ SEG_POL;
            digit_sel_reg <= NUM_DIGITS'(1) ^ SEL_POL;
        end else begin
            segments_reg  <= seg_decode(digit_cur[idx_reg]) ^ SEG_POL;
            digit_sel_reg <= (NUM_DIGITS'(1) << idx_reg) ^ SEL_POL;
        end
    end

    assign bcd_out   = bcd_reg;
    assign tick      = tick_reg;
    assign wrap      = wrap_reg;
    assign segments  = segments_reg;
    assign digit_sel = digit_sel_reg;

endmodule

// File: tb/tb_seg7_mux_counter.sv
// Bench for seg7_mux_counter. Two instances share all inputs: a common-cathode
// one and a common-anode one. A decimal reference model predicts every cycle
// and pushes the expected outputs into a scoreboard queue. A monitor pops the
// queue and compares after each edge.
module tb_seg7_mux_counter;

    localparam int              ND   = 4;
    localparam logic [23:0]     MAXC = 24'd40;
    localparam logic [15:0]     RDIV = 16'd4;
    localparam int              MODV = 10000;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  div_in;
    logic        enable, up_down, load;
    logic [15:0] load_value;

    logic [15:0] bcd0, bcd1;
    logic        tick0, tick1, wrap0, wrap1;
    logic [6:0]  seg0, seg1;
    logic [3:0]  sel0, sel1;

    always #5 clk = ~clk;

    seg7_mux_counter #(.NUM_DIGITS(ND), .PRESCALE_W(24), .MAX_COUNT(MAXC),
                       .REFRESH_DIV(RDIV), .COMMON_ANODE(1'b0)) dut_cc (
        .clk(clk), .reset(reset), .div_in(div_in), .enable(enable),
        .up_down(up_down), .load(load), .load_value(load_value),
        .bcd_out(bcd0), .tick(tick0), .wrap(wrap0), .segments(seg0), .digit_sel(sel0));

    seg7_mux_counter #(.NUM_DIGITS(ND), .PRESCALE_W(24), .MAX_COUNT(MAXC),
                       .REFRESH_DIV(RDIV), .COMMON_ANODE(1'b1)) dut_ca (
        .clk(clk), .reset(reset), .div_in(div_in), .enable(enable),
        .up_down(up_down), .load(load), .load_value(load_value),
        .bcd_out(bcd1), .tick(tick1), .wrap(wrap1), .segments(seg1), .digit_sel(sel1));

    typedef struct packed {
        logic [15:0] bcd;
        logic        tick;
        logic        wrap;
        logic [6:0]  seg;
        logic [3:0]  sel;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycle    = 0;

    // Reference model state, kept as plain integers.
    int       m_pre, m_val, m_ref, m_idx;
    bit       m_tick, m_wrap;
    logic [6:0] m_seg;
    logic [3:0] m_sel;

    logic [6:0] glyph [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic int pow10(input int e);
        int p = 1;
        for (int i = 0; i < e; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic int load_to_int(input logic [15:0] lv);
        int v = 0;
        for (int i = 0; i < ND; i++) begin
            int d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            v = v + d * pow10(i);
        end
        return v;
    endfunction

    function automatic int cur_cmp();
        return (div_in == 8'd0) ? int'(MAXC) : int'(div_in) * 1024;
    endfunction

    // Model: predict the state after this edge and push it for the monitor.
    always @(posedge clk) begin
        int old_val, old_idx;
        exp_t e;
        cycle++;
        if (reset) begin
            m_pre = 0; m_tick = 0; m_val = 0; m_wrap = 0;
            m_ref = 0; m_idx = 0; m_sel = 4'b0001; m_seg = 7'h3F;
        end else begin
            old_val = m_val;
            old_idx = m_idx;
            if (load) begin
                m_val = load_to_int(load_value);
                m_pre = 0; m_tick = 0; m_wrap = 0;
            end else begin
                if (m_tick) begin
                    if (up_down) begin
                        m_wrap = (m_val == MODV - 1);
                        m_val  = (m_val + 1) % MODV;
                    end else begin
                        m_wrap = (m_val == 0);
                        m_val  = (m_val + MODV - 1) % MODV;
                    end
                end else begin
                    m_wrap = 0;
                end
                if (enable) begin
                    if (m_pre == cur_cmp()) begin
                        m_pre = 0; m_tick = 1;
                    end else begin
                        m_pre = (m_pre + 1) % (1 << 24); m_tick = 0;
                    end
                end else begin
                    m_tick = 0;
                end
            end
            m_seg = glyph[(old_val / pow10(old_idx)) % 10];
            m_sel = 4'(1 << old_idx);
            if (m_ref == int'(RDIV) - 1) begin
                m_ref = 0;
                m_idx = (m_idx + 1) % ND;
            end else begin
                m_ref++;
            end
        end
        e.bcd = to_bcd(m_val); e.tick = m_tick; e.wrap = m_wrap;
        e.seg = m_seg; e.sel = m_sel;
        sb_q.push_back(e);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, cycle, act, exp);
        end
    endtask

    // Monitor: pop the prediction for this edge and compare both instances.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sb_q.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("cc_bcd",  {16'd0, bcd0},  {16'd0, e.bcd});
            chk("cc_tick", {31'd0, tick0}, {31'd0, e.tick});
            chk("cc_wrap", {31'd0, wrap0}, {31'd0, e.wrap});
            chk("cc_seg",  {25'd0, seg0},  {25'd0, e.seg});
            chk("cc_sel",  {28'd0, sel0},  {28'd0, e.sel});
            chk("ca_bcd",  {16'd0, bcd1},  {16'd0, e.bcd});
            chk("ca_tick", {31'd0, tick1}, {31'd0, e.tick});
            chk("ca_wrap", {31'd0, wrap1}, {31'd0, e.wrap});
            chk("ca_seg",  {25'd0, seg1},  {25'd0, ~e.seg});
            chk("ca_sel",  {28'd0, sel1},  {28'd0, ~e.sel});
            if (e.tick || e.wrap)
                $display("cycle %0d: tick=%0b wrap=%0b bcd=%h", cycle, e.tick, e.wrap, e.bcd);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; load_value = v;
        cyc(1);
        load = 1'b0;
        $display("cycle %0d: load %h", cycle, v);
    endtask

    // Wait, with a bound, until the model says pre is at terminal (sel=0) or tick is high (sel=1).
    task automatic wait_model(input bit sel, input string name);
        bit hit = 0;
        for (int k = 0; k < 300 && !hit; k++) begin
            @(negedge clk);
            if (sel ? m_tick : (m_pre == cur_cmp())) hit = 1;
        end
        if (!hit) chk(name, 32'd0, 32'd1);
    endtask

    initial begin
        reset = 1'b1; div_in = 8'd0; enable = 1'b0; up_down = 1'b1;
        load = 1'b0; load_value = '0;
        cyc(3);
        reset = 1'b0;
        $display("cycle %0d: reset released", cycle);

        // Tick period with div_in=1: 1025 clocks per tick.
        div_in = 8'd1; enable = 1'b1; up_down = 1'b1;
        cyc(2200);

        // Up wrap from 9998.
        div_in = 8'd0;
        do_load(16'h9998);
        cyc(100);

        // Load clamp, then down wrap from 0.
        do_load(16'h12F4);
        cyc(2);
        up_down = 1'b0;
        do_load(16'h0000);
        cyc(50);

        // Hold.
        enable = 1'b0;
        cyc(3000);
        enable = 1'b1;

        // Load in the cycle where pre reaches terminal, then in the cycle where tick is high.
        wait_model(1'b0, "wait_pre_terminal");
        do_load(16'h4321);
        cyc(10);
        wait_model(1'b1, "wait_tick_high");
        do_load(16'h0567);
        cyc(10);

        // div_in raised then dropped so that pre exceeds cmp; then reset mid-count.
        div_in = 8'd1;
        cyc(600);
        div_in = 8'd0;
        cyc(50);
        reset = 1'b1; cyc(1); reset = 1'b0;
        do_load(16'h1234);
        enable = 1'b0;
        cyc(40);
        enable = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            load       = ($urandom_range(0, 39) == 0);
            load_value = 16'($urandom);
            enable     = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 49) == 0) up_down = ~up_down;
            div_in     = ($urandom_range(0, 299) == 0) ? 8'd1 : 8'd0;
            reset      = ($urandom_range(0, 599) == 0);
            cyc(1);
        end
        load = 1'b0; reset = 1'b0;
        cyc(3);
        @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
